// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among three requesters.
// Optional BUSY watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [47:0] req_data,
  input  logic [8:0]  req_ss,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic [7:0]  rdata,
  output logic [15:0] SPI_data,
  output logic [2:0]  ss,
  output logic        wrt_SPI,
  input  logic        SPI_done,
  input  logic [7:0]  SPI_rdata
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] data_q, data_d;
  logic [2:0]  ss_q, ss_d;
  logic        wrt_q, wrt_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  cand_s;
  logic [1:0]  win_idx_s;
  logic        win_vld_s;
  logic        hit_s;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    err_q, err_d;
`endif

  // Winner search: last+1, last+2, last (mod 3).
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = 2'd0;
    cand_s    = 2'd0;
    hit_s     = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cand_s    = 2'((32'(last_q) + 32'(k)) % 32'd3);
      hit_s     = !win_vld_s && req[cand_s];
      win_idx_s = hit_s ? cand_s : win_idx_s;
      win_vld_s = win_vld_s | hit_s;
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 3'b000;
    rdata_d = rdata_q;
    data_d  = data_q;
    ss_d    = ss_q;
    wrt_d   = 1'b0;
    last_d  = last_q;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 3'b000;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld_s) begin
          gnt_d   = 3'b001 << win_idx_s;
          data_d  = req_data[{win_idx_s, 4'b0000} +: 16];
          ss_d    = req_ss[32'd3 * 32'(win_idx_s) +: 3];
          last_d  = win_idx_s;
          wrt_d   = 1'b1;
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = BUSY;
      end
      BUSY: begin
        if (SPI_done) begin
          rdata_d = SPI_rdata;
          done_d  = gnt_q;
          state_d = DONE;
        end else begin
`ifdef SPI_ARB_TIMEOUT_EN
          // Expiry is judged on the incremented count so DONE lands TIMEOUT cycles after LAUNCH.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) begin
            done_d  = gnt_q;
            err_d   = gnt_q;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      DONE: begin
        gnt_d   = 3'b000;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 3'b000;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      done_q  <= 3'b000;
      rdata_q <= 8'h00;
      data_q  <= 16'h0000;
      ss_q    <= 3'b000;
      wrt_q   <= 1'b0;
      last_q  <= 2'd2;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      data_q  <= data_d;
      ss_q    <= ss_d;
      wrt_q   <= wrt_d;
      last_q  <= last_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign SPI_data = data_q;
  assign ss       = ss_q;
  assign wrt_SPI  = wrt_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 3'b000;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios plus random traffic
// checked against a round-robin reference model.
module tb_spi_arbiter;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [47:0] req_data;
  logic [8:0]  req_ss;
  logic [2:0]  gnt, done, err, ss;
  logic [7:0]  rdata, SPI_rdata;
  logic [15:0] SPI_data;
  logic        wrt_SPI, SPI_done;

  int errors = 0;
  int checks = 0;
  int model_last;
  logic [7:0] exp_rdata;

  spi_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ss(req_ss),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .SPI_data(SPI_data),
    .ss(ss), .wrt_SPI(wrt_SPI), .SPI_done(SPI_done), .SPI_rdata(SPI_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first set request scanning last+1, last+2, last (mod 3).
  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  // Starts in an IDLE cycle with req already driven; returns at the IDLE cycle after DONE.
  task automatic txn(input int wait_n, input logic [7:0] rd, input logic drop_req,
                     input logic spur_launch, output int winner);
    int w;
    logic [2:0] g;
    w = pick(req, model_last);
    winner = w;
    g = 3'b001 << w;
    chk("idle_gnt", 32'(gnt), 32'h0);
    tick();
    chk("launch_gnt", 32'(gnt), 32'(g));
    chk("launch_wrt", 32'(wrt_SPI), 32'h1);
    chk("launch_data", 32'(SPI_data), 32'(req_data[16*w +: 16]));
    chk("launch_ss", 32'(ss), 32'(req_ss[3*w +: 3]));
    model_last = w;
    if (spur_launch) SPI_done = 1'b1;
    tick();
    SPI_done = 1'b0;
    chk("busy_wrt", 32'(wrt_SPI), 32'h0);
    for (int k = 0; k < wait_n; k++) begin
      chk("busy_no_done", 32'({done, err}), 32'h0);
      chk("busy_gnt", 32'(gnt), 32'(g));
      tick();
    end
    SPI_done  = 1'b1;
    SPI_rdata = rd;
    tick();
    SPI_done  = 1'b0;
    SPI_rdata = $urandom;
    if (drop_req) req = 3'b000;
    exp_rdata = rd;
    chk("done_pulse", 32'(done), 32'(g));
    chk("done_err", 32'(err), 32'h0);
    chk("done_rdata", 32'(rdata), 32'(exp_rdata));
    chk("done_gnt", 32'(gnt), 32'(g));
    tick();
    chk("idle_gnt_clr", 32'(gnt), 32'h0);
    chk("idle_done_clr", 32'(done), 32'h0);
    chk("idle_wrt", 32'(wrt_SPI), 32'h0);
  endtask

  initial begin
    int w;
    rst = 1'b1; req = 3'b000; req_data = 48'h0; req_ss = 9'h0;
    SPI_done = 1'b0; SPI_rdata = 8'h00;
    model_last = 2; exp_rdata = 8'h00;
    tick(); tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_wrt", 32'(wrt_SPI), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_data", 32'(SPI_data), 32'h0);
    chk("rst_ss", 32'(ss), 32'h0);
    rst = 1'b0;
    tick();

    // Round-robin with all requesters held: order 0,1,2,0,1,2.
    req = 3'b111;
    req_data = {16'hC2C2, 16'hB1B1, 16'hA0A0};
    req_ss = {3'b100, 3'b010, 3'b001};
    for (int i = 0; i < 6; i++) begin
      txn(5, 8'(i + 8'h40), (i == 5), 1'b0, w);
      chk("rr_order", 32'(w), 32'(i % 3));
    end

    // Single request with fixed values; SPI_done eight cycles into BUSY.
    tick();
    req = 3'b001; req_data[15:0] = 16'h13A5; req_ss[2:0] = 3'b001;
    txn(8, 8'h5C, 1'b1, 1'b0, w);
    chk("single_win", 32'(w), 32'h0);

    // Spurious SPI_done in IDLE is ignored.
    SPI_done = 1'b1;
    tick();
    SPI_done = 1'b0;
    chk("spur_idle_done", 32'(done), 32'h0);
    chk("spur_idle_gnt", 32'(gnt), 32'h0);
    chk("spur_idle_rdata", 32'(rdata), 32'(exp_rdata));
    // Spurious SPI_done in LAUNCH is ignored; the real one completes.
    req = 3'b010;
    txn(3, 8'h99, 1'b1, 1'b1, w);

    // Reset in BUSY, then requester 2 requests.
    req = 3'b010; req_data[31:16] = 16'hDEAD; req_ss[5:3] = 3'b110;
    tick(); tick(); tick();
    rst = 1'b1; req = 3'b100; req_data[47:32] = 16'h7E57; req_ss[8:6] = 3'b011;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_rdata", 32'(rdata), 32'h0);
    chk("mid_rst_data", 32'(SPI_data), 32'h0);
    chk("mid_rst_ss", 32'(ss), 32'h0);
    chk("mid_rst_wrt", 32'(wrt_SPI), 32'h0);
    rst = 1'b0;
    model_last = 2; exp_rdata = 8'h00;
    txn(2, 8'h3C, 1'b1, 1'b0, w);
    chk("post_rst_win", 32'(w), 32'h2);

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog expiry: done and err together TIMEOUT cycles after LAUNCH.
    req = 3'b001;
    tick();
    chk("to_launch_wrt", 32'(wrt_SPI), 32'h1);
    model_last = 0;
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      chk("to_wait", 32'({done, err}), 32'h0);
    end
    tick();
    req = 3'b000;
    chk("to_done", 32'(done), 32'h1);
    chk("to_err", 32'(err), 32'h1);
    chk("to_rdata", 32'(rdata), 32'(exp_rdata));
    tick();
    chk("to_gnt_clr", 32'(gnt), 32'h0);
    // SPI_done on the expiry cycle is a normal completion.
    req = 3'b010;
    txn(TO - 2, 8'hE1, 1'b1, 1'b0, w);
`else
    // Without the watchdog BUSY waits indefinitely.
    req = 3'b010;
    txn(40, 8'hE1, 1'b1, 1'b0, w);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 25; i++) begin
      if (req == 3'b000 || $urandom_range(0, 1) == 1) req = req | 3'($urandom_range(1, 7));
      req_data = {$urandom, $urandom};
      req_ss = 9'($urandom);
      txn($urandom_range(0, 6), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
